// File: rtl/cam_frame_writer_pkg.sv
// ---------------------------------------------------------------------------
// cam_frame_writer_pkg
//  Shared definitions for the camera frame writer path: data widths, the
//  write-sequencer state encoding and the pixel-to-word packing rule.
// ---------------------------------------------------------------------------
package cam_frame_writer_pkg;

  localparam int PIX_W  = 9;   // RGB333 pixel {r[2:0],g[2:0],b[2:0]}
  localparam int ADDR_W = 20;  // SRAM word address width
  localparam int WORD_W = 32;  // SRAM word width

  // Write sequencer states; the encoding is visible on the debug status port.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } wr_state_e;

  // Three pixels per word, earliest pixel in the low bits, top 5 bits zero.
  function automatic logic [WORD_W-1:0] pack_word(
    input logic [PIX_W-1:0] p0,
    input logic [PIX_W-1:0] p1,
    input logic [PIX_W-1:0] p2
  );
    return {5'b0, p2, p1, p0};
  endfunction

endpackage

// File: rtl/cam_frame_writer_fifo.sv
// ---------------------------------------------------------------------------
// sync_word_fifo
//  Single-clock word FIFO with synchronous flush. The head entry is always
//  presented on head_data; pop advances past it.
//  Ports:
//   clk, rst       clock, asynchronous active-high reset
//   flush          empties the FIFO (overrides push/pop that cycle)
//   push/push_data write request and data
//   pop            remove head entry (ignored when empty)
//   head_data      current head entry
//   full, empty    occupancy flags
// ---------------------------------------------------------------------------
module sync_word_fifo #(
  parameter int DEPTH = 8,   // power of two, >= 2
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;  // extra wrap bit separates full from empty

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // A pop in the same cycle frees the slot, so a push into a full FIFO is
  // still accepted when paired with a pop.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign head_data = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage carries no reset; the pointers define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/cam_frame_writer.sv
// ---------------------------------------------------------------------------
// cam_frame_writer
//  Packs the camera's 9-bit RGB333 pixel stream three pixels per 32-bit word,
//  queues words in a small FIFO and writes them to consecutive SRAM addresses
//  through ram_ctrl's write/workdone handshake. A frame spans FRAME_WORDS
//  words starting at BASE_ADDR.
//  Ports:
//   clk, rst     clock, asynchronous active-high reset
//   frame_start  1-cycle pulse at the start of a camera frame
//   pix_valid    pix_data valid this cycle
//   pix_data     pixel {r,g,b}
//   mem_write    1-cycle write request
//   mem_addr     write address, held until mem_done
//   mem_data     write data {5'b0,p2,p1,p0}
//   mem_done     1-cycle acknowledge ending the current write
//   frame_done   1-cycle pulse after the frame's last word is acknowledged
//   overflow     sticky: a packed word was dropped on a full FIFO
//   status       {overflow, fifo_empty, state[1:0]}
// ---------------------------------------------------------------------------
module cam_frame_writer
  import cam_frame_writer_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 20'h00000,
  parameter int                FRAME_WORDS = 102400,
  parameter int                FIFO_DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  input  logic              pix_valid,
  input  logic [PIX_W-1:0]  pix_data,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_data,
  input  logic              mem_done,
  output logic              frame_done,
  output logic              overflow,
  output logic [3:0]        status
);

  localparam logic [ADDR_W-1:0] LAST_CNT = ADDR_W'(FRAME_WORDS - 1);

  // Packer
  logic [1:0]        pack_cnt_q, pack_cnt_d;
  logic [PIX_W-1:0]  slot0_q, slot0_d;
  logic [PIX_W-1:0]  slot1_q, slot1_d;
  logic [1:0]        pack_slot;

  // FIFO interface
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [WORD_W-1:0] fifo_head;
  logic [WORD_W-1:0] push_word;

  // Write sequencer
  wr_state_e         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] word_cnt_q, word_cnt_d;
  logic [WORD_W-1:0] data_q, data_d;
  logic              frame_done_q, frame_done_d;
  logic              overflow_q, overflow_d;
  // frame_start seen while a write was in flight: rewind on its mem_done.
  logic              restart_pend_q, restart_pend_d;

  // -------------------------------------------------------------------------
  // Pixel packer. A pixel arriving together with frame_start is the first
  // pixel of the new frame, so the slot index is forced to 0 that cycle.
  // -------------------------------------------------------------------------
  assign pack_slot = frame_start ? 2'd0 : pack_cnt_q;
  assign push_word = pack_word(slot0_q, slot1_q, pix_data);

  always_comb begin
    pack_cnt_d = pack_cnt_q;
    slot0_d    = slot0_q;
    slot1_d    = slot1_q;
    fifo_push  = 1'b0;
    if (frame_start) pack_cnt_d = 2'd0;
    if (pix_valid) begin
      case (pack_slot)
        2'd0: begin
          slot0_d    = pix_data;
          pack_cnt_d = 2'd1;
        end
        2'd1: begin
          slot1_d    = pix_data;
          pack_cnt_d = 2'd2;
        end
        default: begin
          fifo_push  = 1'b1;
          pack_cnt_d = 2'd0;
        end
      endcase
    end
  end

  sync_word_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (WORD_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (frame_start),
    .push      (fifo_push),
    .push_data (push_word),
    .pop       (fifo_pop),
    .head_data (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // -------------------------------------------------------------------------
  // Sequencer: state register / next state / outputs.
  // A frame_start in IDLE flushes the FIFO, so no word is popped that cycle.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (!fifo_empty && !frame_start) state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT:  if (mem_done) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_write = (state_q == ST_ISSUE);
    fifo_pop  = (state_q == ST_IDLE) && !fifo_empty && !frame_start;
  end

  // -------------------------------------------------------------------------
  // Address / count / data bookkeeping.
  // -------------------------------------------------------------------------
  always_comb begin
    addr_d         = addr_q;
    word_cnt_d     = word_cnt_q;
    data_d         = data_q;
    frame_done_d   = 1'b0;
    restart_pend_d = restart_pend_q;
    // Dropped only when the push cannot ride on a simultaneous pop.
    overflow_d     = overflow_q | (fifo_push && fifo_full && !fifo_pop);

    if (fifo_pop) data_d = fifo_head;

    if (frame_start) begin
      if (state_q == ST_IDLE) begin
        addr_d         = BASE_ADDR;
        word_cnt_d     = '0;
        restart_pend_d = 1'b0;
      end else begin
        restart_pend_d = 1'b1;
      end
    end

    if ((state_q == ST_WAIT) && mem_done) begin
      if (restart_pend_q || frame_start) begin
        // Write belonged to an abandoned frame: rewind without frame_done.
        addr_d         = BASE_ADDR;
        word_cnt_d     = '0;
        restart_pend_d = 1'b0;
      end else if (word_cnt_q == LAST_CNT) begin
        addr_d       = BASE_ADDR;
        word_cnt_d   = '0;
        frame_done_d = 1'b1;
      end else begin
        addr_d     = addr_q + 1'b1;
        word_cnt_d = word_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pack_cnt_q     <= 2'd0;
      slot0_q        <= '0;
      slot1_q        <= '0;
      addr_q         <= BASE_ADDR;
      word_cnt_q     <= '0;
      data_q         <= '0;
      frame_done_q   <= 1'b0;
      overflow_q     <= 1'b0;
      restart_pend_q <= 1'b0;
    end else begin
      pack_cnt_q     <= pack_cnt_d;
      slot0_q        <= slot0_d;
      slot1_q        <= slot1_d;
      addr_q         <= addr_d;
      word_cnt_q     <= word_cnt_d;
      data_q         <= data_d;
      frame_done_q   <= frame_done_d;
      overflow_q     <= overflow_d;
      restart_pend_q <= restart_pend_d;
    end
  end

  assign mem_addr   = addr_q;
  assign mem_data   = data_q;
  assign frame_done = frame_done_q;
  assign overflow   = overflow_q;
  assign status     = {overflow_q, fifo_empty, state_q};

endmodule
